// File: rtl/zigbee_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zigbee_mux_pkg
// Description : Shared constants and types for the zigbee pin-mux host side.
// Revision    : 1.0 - initial release
// ============================================================================
package zigbee_mux_pkg;

    localparam int SEL_W     = 2;
    localparam int NB_PHASES = 1 << SEL_W;
    localparam int PIN_IN_W  = 22;
    localparam int PIN_OUT_W = 18;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } mux_host_state_e;

    typedef logic [NB_PHASES-1:0][PIN_IN_W-1:0]  tx_frame_t;
    typedef logic [NB_PHASES-1:0][PIN_OUT_W-1:0] rx_frame_t;

endpackage
`default_nettype wire

// File: rtl/zigbee_mux_sync.sv
`default_nettype none
// ============================================================================
// Module      : zigbee_mux_sync
// Description : Parameterised-width two-flop synchroniser for pad inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module zigbee_mux_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/zigbee_mux_host.sv
`default_nettype none
// ============================================================================
// Module      : zigbee_mux_host
// Description : Host side of the zigbee pad-ring pin mux: follows the chip's
//               phase select, drives tx slices and assembles rx frames.
//               Optional macro ZIGBEE_MUX_HOST_SEQCHK_EN adds seq_err_o and
//               seq_err_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module zigbee_mux_host
    import zigbee_mux_pkg::*;
#(
    parameter int NB_PHASES  = zigbee_mux_pkg::NB_PHASES,
    parameter int SEL_W      = zigbee_mux_pkg::SEL_W,
    parameter int PIN_IN_W   = zigbee_mux_pkg::PIN_IN_W,
    parameter int PIN_OUT_W  = zigbee_mux_pkg::PIN_OUT_W,
    parameter int STABLE_CYC = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [SEL_W-1:0]                sel_i,
    input  logic [PIN_OUT_W-1:0]            pin_i,
    output logic [PIN_IN_W-1:0]             pin_o,
    input  logic                            tx_valid_i,
    output logic                            tx_ready_o,
    input  logic [NB_PHASES*PIN_IN_W-1:0]   tx_data_i,
    output logic                            rx_valid_o,
    input  logic                            rx_ready_i,
    output logic [NB_PHASES*PIN_OUT_W-1:0]  rx_data_o,
    output logic                            locked_o,
`ifdef ZIGBEE_MUX_HOST_SEQCHK_EN
    output logic                            overrun_o,
    output logic                            seq_err_o,
    output logic [15:0]                     seq_err_cnt_o
`else
    output logic                            overrun_o
`endif
);

    localparam logic [3:0]       c_acc_cnt = 4'(STABLE_CYC - 1);
    localparam logic [SEL_W-1:0] c_last_ph = SEL_W'(NB_PHASES - 1);

    logic [SEL_W-1:0]     w_sel_s;
    logic [PIN_OUT_W-1:0] w_pin_s;
    logic                 w_same;
    logic                 w_acc;

    logic [SEL_W-1:0]     r_sel_prev;
    logic [3:0]           r_stab_cnt;
    logic                 r_acc_vld;
    logic [SEL_W-1:0]     r_acc_sel;

    mux_host_state_e                      r_state;
    logic [SEL_W-1:0]                     r_expect;
    logic [NB_PHASES-1:0][PIN_IN_W-1:0]   r_tx_frame;
    logic [NB_PHASES-1:0][PIN_OUT_W-1:0]  r_rx_part;
    logic [NB_PHASES-1:0][PIN_OUT_W-1:0]  r_rx_data;
    logic                                 r_rx_valid;
    logic                                 r_locked;
    logic                                 r_overrun;
    logic [PIN_IN_W-1:0]                  r_pin_o;
`ifdef ZIGBEE_MUX_HOST_SEQCHK_EN
    logic                                 r_seq_err;
    logic [15:0]                          r_seq_err_cnt;
`endif

    zigbee_mux_sync #(.WIDTH(SEL_W)) u_sel_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (sel_i),
        .o_q (w_sel_s)
    );

    zigbee_mux_sync #(.WIDTH(PIN_OUT_W)) u_pin_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (pin_i),
        .o_q (w_pin_s)
    );

    // A sel value is accepted once; a glitch back to the last accepted value
    // must not produce a second acceptance.
    assign w_same = (w_sel_s == r_sel_prev);
    assign w_acc  = w_same && (r_stab_cnt == c_acc_cnt) &&
                    !(r_acc_vld && (r_acc_sel == w_sel_s));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sel_prev <= '0;
            r_stab_cnt <= '0;
            r_acc_vld  <= 1'b0;
            r_acc_sel  <= '0;
        end else begin
            r_sel_prev <= w_sel_s;
            if (!w_same)
                r_stab_cnt <= '0;
            else if (r_stab_cnt != 4'hF)
                r_stab_cnt <= r_stab_cnt + 4'd1;
            if (w_acc) begin
                r_acc_vld <= 1'b1;
                r_acc_sel <= w_sel_s;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= HUNT;
            r_expect   <= '0;
            r_tx_frame <= '0;
            r_rx_part  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_locked   <= 1'b0;
            r_overrun  <= 1'b0;
            r_pin_o    <= '0;
`ifdef ZIGBEE_MUX_HOST_SEQCHK_EN
            r_seq_err     <= 1'b0;
            r_seq_err_cnt <= '0;
`endif
        end else begin
`ifdef ZIGBEE_MUX_HOST_SEQCHK_EN
            r_seq_err <= 1'b0;
`endif
            if (r_rx_valid && rx_ready_i)
                r_rx_valid <= 1'b0;
            r_pin_o <= (r_state == HUNT) ? '0 : r_tx_frame[w_sel_s];

            case (r_state)
                HUNT: begin
                    if (w_acc && (w_sel_s == c_last_ph))
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_tx_frame <= tx_valid_i ? tx_data_i : '0;
                    r_expect   <= '0;
                    r_rx_part  <= '0;
                    r_locked   <= 1'b1;
                    r_state    <= RUN;
                end
                RUN: begin
                    if (w_acc) begin
                        if (w_sel_s == r_expect) begin
                            r_rx_part[w_sel_s] <= w_pin_s;
                            if (r_expect == c_last_ph) begin
                                // Unaccepted old frame wins; the new one is dropped.
                                if (r_rx_valid && !rx_ready_i) begin
                                    r_overrun <= 1'b1;
                                end else begin
                                    r_rx_data  <= {w_pin_s, r_rx_part[NB_PHASES-2:0]};
                                    r_rx_valid <= 1'b1;
                                end
                                r_state <= LOAD;
                            end else begin
                                r_expect <= r_expect + SEL_W'(1);
                            end
                        end else begin
                            r_locked  <= 1'b0;
                            r_rx_part <= '0;
                            r_state   <= HUNT;
`ifdef ZIGBEE_MUX_HOST_SEQCHK_EN
                            r_seq_err <= 1'b1;
                            if (r_seq_err_cnt != 16'hFFFF)
                                r_seq_err_cnt <= r_seq_err_cnt + 16'd1;
`endif
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    assign pin_o      = r_pin_o;
    assign tx_ready_o = (r_state == LOAD) && tx_valid_i;
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
    assign locked_o   = r_locked;
    assign overrun_o  = r_overrun;
`ifdef ZIGBEE_MUX_HOST_SEQCHK_EN
    assign seq_err_o     = r_seq_err;
    assign seq_err_cnt_o = r_seq_err_cnt;
`endif

endmodule
`default_nettype wire
